// File: rtl/mem_line_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_line_arbiter
//
// Shares one 32-bit external memory port between three line-transfer clients:
// DCache dirty-line writeback (DC_LW), DCache line fill (DC_LB) and ICache
// line fill (IC_LB). Each 8-word line is moved as 8 word beats with a
// Mem_Req/Mem_Ack handshake. Fill beats are assembled into LB_LineData.
//
// Ports
//   Clk, Rst                 clock, synchronous active-high reset
//   DC_LW_Enable/Addr/Data   writeback request, line address, 256-bit line
//   DC_LW_Completed          one-cycle pulse when the writeback is done
//   DC_LB_Enable/Addr        DCache fill request and critical word address
//   DC_LB_FirstWord          pulse: critical word available in LB_CritWord
//   DC_LB_Completed          pulse: full line available in LB_LineData
//   IC_LB_*                  same as DC_LB_* for the ICache
//   LB_LineData/LineAddr     assembled fill line and its line-aligned address
//   LB_CritWord              first word returned by the current fill
//   Busy                     high whenever the FSM is not idle
//   Mem_Req/WE/Addr/WData    registered beat request towards memory
//   Mem_RData/Ack            read data and beat acknowledge from memory
//
// Configuration macro
//   CRITICAL_WORD_FIRST_EN   when defined, a fill starts at the requested
//                            word and wraps; otherwise fills start at word 0.
//                            Writebacks always start at word 0.
// ---------------------------------------------------------------------------
module mem_line_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int AW         = 32
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     DC_LW_Enable,
    input  logic [AW-1:0]            DC_LW_Addr,
    input  logic [32*LINE_WORDS-1:0] DC_LW_Data,
    output logic                     DC_LW_Completed,
    input  logic                     DC_LB_Enable,
    input  logic [AW-1:0]            DC_LB_Addr,
    output logic                     DC_LB_FirstWord,
    output logic                     DC_LB_Completed,
    input  logic                     IC_LB_Enable,
    input  logic [AW-1:0]            IC_LB_Addr,
    output logic                     IC_LB_FirstWord,
    output logic                     IC_LB_Completed,
    output logic [32*LINE_WORDS-1:0] LB_LineData,
    output logic [AW-1:0]            LB_LineAddr,
    output logic [31:0]              LB_CritWord,
    output logic                     Busy,
    output logic                     Mem_Req,
    output logic                     Mem_WE,
    output logic [AW-1:0]            Mem_Addr,
    output logic [31:0]              Mem_WData,
    input  logic [31:0]              Mem_RData,
    input  logic                     Mem_Ack
);

    localparam int LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_e;
    typedef enum logic [1:0] {CL_LW, CL_DLB, CL_ILB} client_e;

    state_e                 state_q, state_d;
    client_e                client_q, client_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2:0]             start_q, start_d;
    logic [AW-4:0]          line_q, line_d;
    logic [2:0]             lock_q, lock_d;      // [0]=DC_LW [1]=DC_LB [2]=IC_LB
    logic [LINE_BITS-1:0]   wbuf_q, wbuf_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [LINE_BITS-1:0]   ldata_q, ldata_d;
    logic [AW-1:0]          laddr_q, laddr_d;
    logic [31:0]            crit_q, crit_d;
    logic                   dc_first_q, dc_first_d;
    logic                   ic_first_q, ic_first_d;
    logic                   lw_done_q, lw_done_d;
    logic                   dc_done_q, dc_done_d;
    logic                   ic_done_q, ic_done_d;

    logic          lw_win, dlb_win, ilb_win;
    logic [AW-1:0] fill_addr;
    logic [2:0]    fill_start;
    logic [2:0]    idx, next_idx;
    logic          beat_ack;
    logic          unused_bits;

    // Fixed priority DC_LW > DC_LB > IC_LB, skipping a client in its lockout cycle.
    assign lw_win    = DC_LW_Enable && !lock_q[0];
    assign dlb_win   = !lw_win && DC_LB_Enable && !lock_q[1];
    assign ilb_win   = !lw_win && !dlb_win && IC_LB_Enable && !lock_q[2];
    assign fill_addr = dlb_win ? DC_LB_Addr : IC_LB_Addr;

`ifdef CRITICAL_WORD_FIRST_EN
    assign fill_start = fill_addr[2:0];
`else
    assign fill_start = 3'd0;
`endif

    // Line offsets of writeback addresses (and of fills without critical-word-first) carry no meaning.
    assign unused_bits = ^{DC_LW_Addr[2:0], fill_addr[2:0]};

    // Beat index wraps modulo 8 through the 3-bit add.
    assign idx      = start_q + cnt_q;
    assign next_idx = idx + 3'd1;
    // An ack only counts against a beat that is actually being presented.
    assign beat_ack = req_q && Mem_Ack;

    always_comb begin
        // NOTE: every next-value signal is given its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        client_d   = client_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        line_d     = line_q;
        lock_d     = lock_q;
        wbuf_d     = wbuf_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ldata_d    = ldata_q;
        laddr_d    = laddr_q;
        crit_d     = crit_q;
        dc_first_d = 1'b0;
        ic_first_d = 1'b0;
        lw_done_d  = 1'b0;
        dc_done_d  = 1'b0;
        ic_done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The lockout mask lives for exactly this one idle cycle.
                lock_d = 3'b000;
                if (lw_win) begin
                    client_d = CL_LW;
                    line_d   = DC_LW_Addr[AW-1:3];
                    start_d  = 3'd0;
                    cnt_d    = 3'd0;
                    wbuf_d   = DC_LW_Data;
                    req_d    = 1'b1;
                    we_d     = 1'b1;
                    addr_d   = {DC_LW_Addr[AW-1:3], 3'd0};
                    wdata_d  = DC_LW_Data[31:0];
                    state_d  = S_WB;
                end else if (dlb_win || ilb_win) begin
                    client_d = dlb_win ? CL_DLB : CL_ILB;
                    line_d   = fill_addr[AW-1:3];
                    start_d  = fill_start;
                    cnt_d    = 3'd0;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = {fill_addr[AW-1:3], fill_start};
                    wdata_d  = '0;
                    laddr_d  = {fill_addr[AW-1:3], 3'd0};
                    state_d  = S_FILL;
                end
            end

            S_WB, S_FILL: begin
                if (beat_ack) begin
                    cnt_d = cnt_q + 3'd1;
                    if (state_q == S_FILL) begin
                        ldata_d[idx*32 +: 32] = Mem_RData;
                        if (cnt_q == 3'd0) begin
                            crit_d     = Mem_RData;
                            dc_first_d = (client_q == CL_DLB);
                            ic_first_d = (client_q == CL_ILB);
                        end
                    end
                    if (cnt_q == 3'(LINE_WORDS - 1)) begin
                        state_d   = S_DONE;
                        req_d     = 1'b0;
                        we_d      = 1'b0;
                        addr_d    = '0;
                        wdata_d   = '0;
                        lw_done_d = (client_q == CL_LW);
                        dc_done_d = (client_q == CL_DLB);
                        ic_done_d = (client_q == CL_ILB);
                    end else begin
                        // Next beat goes out in the cycle right after the ack.
                        addr_d  = {line_q, next_idx};
                        wdata_d = (state_q == S_WB) ? wbuf_q[next_idx*32 +: 32] : 32'd0;
                    end
                end
            end

            S_DONE: begin
                lock_d  = {client_q == CL_ILB, client_q == CL_DLB, client_q == CL_LW};
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            client_q   <= CL_LW;
            cnt_q      <= 3'd0;
            start_q    <= 3'd0;
            line_q     <= '0;
            lock_q     <= 3'b000;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ldata_q    <= '0;
            laddr_q    <= '0;
            crit_q     <= '0;
            dc_first_q <= 1'b0;
            ic_first_q <= 1'b0;
            lw_done_q  <= 1'b0;
            dc_done_q  <= 1'b0;
            ic_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            client_q   <= client_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            line_q     <= line_d;
            lock_q     <= lock_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ldata_q    <= ldata_d;
            laddr_q    <= laddr_d;
            crit_q     <= crit_d;
            dc_first_q <= dc_first_d;
            ic_first_q <= ic_first_d;
            lw_done_q  <= lw_done_d;
            dc_done_q  <= dc_done_d;
            ic_done_q  <= ic_done_d;
        end
    end

    // NOTE: the writeback buffer is reloaded at every writeback grant before it is read, so it carries no reset.
    always_ff @(posedge Clk) begin
        wbuf_q <= wbuf_d;
    end

    assign DC_LW_Completed = lw_done_q;
    assign DC_LB_FirstWord = dc_first_q;
    assign DC_LB_Completed = dc_done_q;
    assign IC_LB_FirstWord = ic_first_q;
    assign IC_LB_Completed = ic_done_q;
    assign LB_LineData     = ldata_q;
    assign LB_LineAddr     = laddr_q;
    assign LB_CritWord     = crit_q;
    assign Busy            = (state_q != S_IDLE);
    assign Mem_Req         = req_q;
    assign Mem_WE          = we_q;
    assign Mem_Addr        = addr_q;
    assign Mem_WData       = wdata_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_line_arbiter. Outputs are sampled on the falling
// edge, inputs are driven there too. Expected beats, data and pulses come from
// a line-transfer model: beat k of a transfer addresses word (start+k) mod 8,
// and the memory returns address+salt for every read.
module tb_mem_line_arbiter;

    logic         Clk;
    logic         Rst;
    logic         DC_LW_Enable;
    logic [31:0]  DC_LW_Addr;
    logic [255:0] DC_LW_Data;
    logic         DC_LW_Completed;
    logic         DC_LB_Enable;
    logic [31:0]  DC_LB_Addr;
    logic         DC_LB_FirstWord;
    logic         DC_LB_Completed;
    logic         IC_LB_Enable;
    logic [31:0]  IC_LB_Addr;
    logic         IC_LB_FirstWord;
    logic         IC_LB_Completed;
    logic [255:0] LB_LineData;
    logic [31:0]  LB_LineAddr;
    logic [31:0]  LB_CritWord;
    logic         Busy;
    logic         Mem_Req;
    logic         Mem_WE;
    logic [31:0]  Mem_Addr;
    logic [31:0]  Mem_WData;
    logic [31:0]  Mem_RData;
    logic         Mem_Ack;

    int vectors;
    int miscompares;

    mem_line_arbiter dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .DC_LW_Enable    (DC_LW_Enable),
        .DC_LW_Addr      (DC_LW_Addr),
        .DC_LW_Data      (DC_LW_Data),
        .DC_LW_Completed (DC_LW_Completed),
        .DC_LB_Enable    (DC_LB_Enable),
        .DC_LB_Addr      (DC_LB_Addr),
        .DC_LB_FirstWord (DC_LB_FirstWord),
        .DC_LB_Completed (DC_LB_Completed),
        .IC_LB_Enable    (IC_LB_Enable),
        .IC_LB_Addr      (IC_LB_Addr),
        .IC_LB_FirstWord (IC_LB_FirstWord),
        .IC_LB_Completed (IC_LB_Completed),
        .LB_LineData     (LB_LineData),
        .LB_LineAddr     (LB_LineAddr),
        .LB_CritWord     (LB_CritWord),
        .Busy            (Busy),
        .Mem_Req         (Mem_Req),
        .Mem_WE          (Mem_WE),
        .Mem_Addr        (Mem_Addr),
        .Mem_WData       (Mem_WData),
        .Mem_RData       (Mem_RData),
        .Mem_Ack         (Mem_Ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word the model expects a fill to begin with.
    function automatic logic [2:0] fill_start(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
        return a[2:0];
`else
        return a[2:0] & 3'b000;
`endif
    endfunction

    // Runs one whole transfer. Entered at a falling edge in an idle cycle whose
    // requests make this client the winner; returns at the falling edge of DONE.
    // waits < 0 picks 0..2 random wait cycles per beat.
    task automatic do_txn(input string tag, input bit is_wb, input bit is_dc,
                          input logic [31:0] req_addr, input int waits,
                          input logic [31:0] salt, input logic [255:0] wline,
                          input bit drop_early);
        logic [31:0]  line_base;
        logic [31:0]  baddr;
        logic [31:0]  exp_wd;
        logic [2:0]   st;
        logic [2:0]   idx;
        logic [255:0] exp_line;
        int           nw;
        line_base = {req_addr[31:3], 3'b000};
        st        = is_wb ? 3'd0 : fill_start(req_addr);
        exp_line  = '0;
        for (int j = 0; j < 8; j++) exp_line[j*32 +: 32] = line_base + 32'(j) + salt;

        check({tag, ".idle_busy"}, Busy, 1'b0);
        @(posedge Clk);
        for (int k = 0; k < 8; k++) begin
            idx    = st + 3'(k);
            baddr  = line_base | {29'd0, idx};
            exp_wd = is_wb ? wline[idx*32 +: 32] : 32'd0;
            nw     = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
            for (int w = 0; w <= nw; w++) begin
                @(negedge Clk);
                if (drop_early && k == 0 && w == 0) begin
                    if (is_wb) DC_LW_Enable = 1'b0;
                    else if (is_dc) DC_LB_Enable = 1'b0;
                    else IC_LB_Enable = 1'b0;
                end
                if (!is_wb && k == 0 && w == 0) check({tag, ".line_addr"}, LB_LineAddr, line_base);
                if (!is_wb && k == 1 && w == 0) begin
                    check({tag, ".dc_first"}, DC_LB_FirstWord, is_dc);
                    check({tag, ".ic_first"}, IC_LB_FirstWord, !is_dc);
                    check({tag, ".crit"}, LB_CritWord, exp_line[st*32 +: 32]);
                end
                check({tag, ".req"}, Mem_Req, 1'b1);
                check({tag, ".we"}, Mem_WE, is_wb);
                check({tag, ".addr"}, Mem_Addr, baddr);
                check({tag, ".wdata"}, Mem_WData, exp_wd);
                Mem_Ack   = (w == nw);
                Mem_RData = baddr + salt;
                @(posedge Clk);
            end
        end
        @(negedge Clk);
        Mem_Ack = 1'b0;
        check({tag, ".done_req"}, Mem_Req, 1'b0);
        check({tag, ".done_busy"}, Busy, 1'b1);
        check({tag, ".lw_done"}, DC_LW_Completed, is_wb);
        check({tag, ".dc_done"}, DC_LB_Completed, !is_wb && is_dc);
        check({tag, ".ic_done"}, IC_LB_Completed, !is_wb && !is_dc);
        check({tag, ".first_low"}, {DC_LB_FirstWord, IC_LB_FirstWord}, 2'b00);
        if (!is_wb) begin
            check({tag, ".line"}, LB_LineData, exp_line);
            check({tag, ".line_addr_done"}, LB_LineAddr, line_base);
        end
    endtask

    initial begin
        logic [255:0] wl;
        logic [31:0]  a;
        logic [31:0]  s;
        int           cl;
        vectors      = 0;
        miscompares  = 0;
        Rst          = 1'b1;
        DC_LW_Enable = 1'b0;
        DC_LW_Addr   = '0;
        DC_LW_Data   = '0;
        DC_LB_Enable = 1'b0;
        DC_LB_Addr   = '0;
        IC_LB_Enable = 1'b0;
        IC_LB_Addr   = '0;
        Mem_RData    = '0;
        Mem_Ack      = 1'b0;

        // Reset state.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst.req", Mem_Req, 1'b0);
        check("rst.busy", Busy, 1'b0);
        check("rst.addr", Mem_Addr, 32'd0);
        check("rst.line", LB_LineData, 256'd0);
        check("rst.laddr", LB_LineAddr, 32'd0);
        check("rst.pulses", {DC_LW_Completed, DC_LB_Completed, IC_LB_Completed,
                             DC_LB_FirstWord, IC_LB_FirstWord}, 5'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Critical-word fill of address 0x105, one ack per cycle.
        DC_LB_Addr   = 32'h0000_0105;
        DC_LB_Enable = 1'b1;
        do_txn("cwf", 1'b0, 1'b1, 32'h0000_0105, 0, 32'h1000, '0, 1'b0);
        DC_LB_Enable = 1'b0;
        repeat (2) @(negedge Clk);

        // Writeback and DCache fill requested together: writeback wins.
        for (int j = 0; j < 8; j++) wl[j*32 +: 32] = 32'hA0 + 32'(j);
        DC_LW_Addr   = 32'h200;
        DC_LW_Data   = wl;
        DC_LB_Addr   = 32'h0000_0303;
        DC_LW_Enable = 1'b1;
        DC_LB_Enable = 1'b1;
        do_txn("wb_first", 1'b1, 1'b0, 32'h200, 0, 32'd0, wl, 1'b0);
        DC_LW_Enable = 1'b0;
        @(negedge Clk);
        do_txn("fill_after_wb", 1'b0, 1'b1, 32'h0000_0303, 0, 32'h5500, '0, 1'b0);
        DC_LB_Enable = 1'b0;
        repeat (2) @(negedge Clk);

        // DC and IC fills together; IC wins the DCache lockout cycle.
        DC_LB_Addr   = 32'h0000_0046;
        IC_LB_Addr   = 32'h0000_0882;
        DC_LB_Enable = 1'b1;
        IC_LB_Enable = 1'b1;
        do_txn("dc_pri", 1'b0, 1'b1, 32'h0000_0046, 0, 32'h7000, '0, 1'b0);
        @(negedge Clk);
        do_txn("ic_lockout", 1'b0, 1'b0, 32'h0000_0882, 0, 32'h9000, '0, 1'b0);
        DC_LB_Enable = 1'b0;
        IC_LB_Enable = 1'b0;
        repeat (2) @(negedge Clk);

        // Writeback with three wait cycles per beat.
        for (int j = 0; j < 8; j++) wl[j*32 +: 32] = $urandom;
        DC_LW_Addr   = 32'h0000_07FD;
        DC_LW_Data   = wl;
        DC_LW_Enable = 1'b1;
        do_txn("wb_wait3", 1'b1, 1'b0, 32'h0000_07FD, 3, 32'd0, wl, 1'b0);
        DC_LW_Enable = 1'b0;
        repeat (2) @(negedge Clk);

        // Acks with no request outstanding change nothing.
        Mem_Ack = 1'b1;
        @(negedge Clk);
        check("stray_ack.req", Mem_Req, 1'b0);
        check("stray_ack.busy", Busy, 1'b0);
        Mem_Ack = 1'b0;
        @(negedge Clk);

        // Reset after four acked fill beats.
        DC_LB_Addr   = 32'h0000_0051;
        DC_LB_Enable = 1'b1;
        @(posedge Clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            Mem_Ack   = 1'b1;
            Mem_RData = 32'hDEAD_0000 + 32'(k);
            @(posedge Clk);
        end
        @(negedge Clk);
        Rst          = 1'b1;
        Mem_Ack      = 1'b0;
        DC_LB_Enable = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("midrst.req", Mem_Req, 1'b0);
        check("midrst.busy", Busy, 1'b0);
        check("midrst.line", LB_LineData, 256'd0);
        check("midrst.laddr", LB_LineAddr, 32'd0);
        check("midrst.crit", LB_CritWord, 32'd0);
        check("midrst.pulses", {DC_LB_Completed, DC_LB_FirstWord}, 2'b00);
        Rst = 1'b0;
        @(negedge Clk);
        check("postrst.done", DC_LB_Completed, 1'b0);

        // Fresh ICache fill after reset; Enable dropped right after the grant.
        a            = $urandom;
        IC_LB_Addr   = a;
        IC_LB_Enable = 1'b1;
        do_txn("ic_after_rst", 1'b0, 1'b0, a, 0, 32'h0BAD_0000, '0, 1'b1);
        repeat (2) @(negedge Clk);

        // Random single-client transfers with random waits.
        for (int t = 0; t < 6; t++) begin
            cl = int'($urandom_range(0, 2));
            a  = $urandom;
            s  = $urandom;
            for (int j = 0; j < 8; j++) wl[j*32 +: 32] = $urandom;
            DC_LW_Addr = a;
            DC_LW_Data = wl;
            DC_LB_Addr = a;
            IC_LB_Addr = a;
            DC_LW_Enable = (cl == 0);
            DC_LB_Enable = (cl == 1);
            IC_LB_Enable = (cl == 2);
            do_txn($sformatf("rnd%0d", t), cl == 0, cl == 1, a, -1, s, wl, 1'b0);
            DC_LW_Enable = 1'b0;
            DC_LB_Enable = 1'b0;
            IC_LB_Enable = 1'b0;
            repeat (2) @(negedge Clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
